// File: rtl/systolic_ctrl.sv
// Sequencing controller for an NxN output-stationary systolic array: clears the
// PEs, streams skewed row/column valids and k indices, drains, then pulses done.
`timescale 1ns/1ps
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int KW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              array_rst_n,
  output logic [N-1:0]      a_row_valid,
  output logic [N*KW-1:0]   a_k,
  output logic [N-1:0]      b_col_valid,
  output logic [N*KW-1:0]   b_k
);

  localparam int TW = $clog2(2 * N);
  localparam logic [TW-1:0] T_FEED_END  = TW'(2 * N - 2);
  localparam logic [TW-1:0] T_DRAIN_END = TW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TW-1:0]     r_t;
  logic [TW-1:0]     w_t_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_array_rst_n;
  logic [N-1:0]      r_vld;
  logic [N*KW-1:0]   r_k;
  logic [N-1:0]      w_vld_nxt;
  logic [N*KW-1:0]   w_k_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_nxt = abort ? S_IDLE : S_FEED;
      end
      S_FEED: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_t == T_FEED_END) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_t_nxt = r_t + 1'b1;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_t == T_DRAIN_END) begin
          w_state_nxt = S_DONE;
        end else begin
          w_t_nxt = r_t + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Diagonal skew: lane i is live for feed steps i..i+N-1 and presents k = t - i.
  always_comb begin
    w_vld_nxt = '0;
    w_k_nxt   = '0;
    if (w_state_nxt == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(w_t_nxt) >= i) && (int'(w_t_nxt) <= i + N - 1)) begin
          w_vld_nxt[i]          = 1'b1;
          w_k_nxt[i*KW +: KW]   = KW'(int'(w_t_nxt) - i);
        end
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_t           <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_array_rst_n <= 1'b0;
      r_vld         <= '0;
      r_k           <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_t           <= w_t_nxt;
      r_busy        <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FEED) ||
                       (w_state_nxt == S_DRAIN);
      r_done        <= (w_state_nxt == S_DONE);
      r_array_rst_n <= (w_state_nxt != S_CLEAR);
      r_vld         <= w_vld_nxt;
      r_k           <= w_k_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign array_rst_n = r_array_rst_n;
  assign a_row_valid = r_vld;
  assign a_k         = r_k;
  assign b_col_valid = r_vld;
  assign b_k         = r_k;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: cycle-indexed output model plus a behavioural
// output-stationary PE array fed from the controller to confirm C = A x B.
`timescale 1ns/1ps
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int KW = $clog2(N);
  localparam int VW = 3 + 2 * N + 2 * N * KW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic            busy;
  logic            done;
  logic            array_rst_n;
  logic [N-1:0]    a_row_valid;
  logic [N*KW-1:0] a_k;
  logic [N-1:0]    b_col_valid;
  logic [N*KW-1:0] b_k;
  logic [VW-1:0]   obs;

  int checks = 0;
  int errors = 0;

  int A [N][N];
  int B [N][N];
  int acc [N][N];
  int ah [N][N];
  int bh [N][N];
  bit av [N][N];
  bit bv [N][N];

  systolic_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .array_rst_n (array_rst_n),
    .a_row_valid (a_row_valid),
    .a_k         (a_k),
    .b_col_valid (b_col_valid),
    .b_k         (b_k)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, array_rst_n, a_row_valid, a_k, b_col_valid, b_k};

  // Behavioural PE grid: operands hop one PE per clock, products accumulate where both are valid.
  always @(posedge clk or posedge rst) begin : pe_model
    int ain, bin;
    bit vai, vbi;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || !array_rst_n) begin
          acc[i][j] <= 0; ah[i][j] <= 0; bh[i][j] <= 0; av[i][j] <= 1'b0; bv[i][j] <= 1'b0;
        end else begin
          if (j == 0) begin
            vai = a_row_valid[i];
            ain = vai ? A[i][a_k[i*KW +: KW]] : 0;
          end else begin
            vai = av[i][j-1];
            ain = ah[i][j-1];
          end
          if (i == 0) begin
            vbi = b_col_valid[j];
            bin = vbi ? B[b_k[j*KW +: KW]][j] : 0;
          end else begin
            vbi = bv[i-1][j];
            bin = bh[i-1][j];
          end
          if (vai && vbi) acc[i][j] <= acc[i][j] + ain * bin;
          ah[i][j] <= ain; av[i][j] <= vai;
          bh[i][j] <= bin; bv[i][j] <= vbi;
        end
      end
    end
  end

  // Expected outputs in cycle c after the start edge (c=0 means idle out of reset).
  function automatic logic [VW-1:0] exp_vec(input int c);
    logic            bsy, dn, arn;
    logic [N-1:0]    v;
    logic [N*KW-1:0] k;
    int              t;
    bsy = (c >= 1) && (c <= 3 * N);
    dn  = (c == 3 * N + 1);
    arn = (c != 1);
    v   = '0;
    k   = '0;
    if (c >= 2 && c <= 2 * N) begin
      t = c - 2;
      for (int i = 0; i < N; i++) begin
        if (t >= i && t <= i + N - 1) begin
          v[i] = 1'b1;
          k[i*KW +: KW] = KW'(t - i);
        end
      end
    end
    return {bsy, dn, arn, v, k, v, k};
  endfunction

  task automatic load_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = $urandom_range(0, 255);
        B[i][j] = $urandom_range(0, 255);
      end
  endtask

  task automatic run_mult(input string tag);
    int ref_c;
    @(negedge clk);
    checks++;
    if (obs !== exp_vec(0)) begin
      errors++;
      $display("FAIL %s idle-before-start obs=%h exp=%h", tag, obs, exp_vec(0));
    end
    start = 1'b1;
    for (int c = 1; c <= 3 * N + 1; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      checks++;
      if (obs !== exp_vec(c)) begin
        errors++;
        $display("FAIL %s cycle=%0d obs=%h exp=%h", tag, c, obs, exp_vec(c));
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ref_c = 0;
        for (int k = 0; k < N; k++) ref_c += A[i][k] * B[k][j];
        checks++;
        if (acc[i][j] !== ref_c) begin
          errors++;
          $display("FAIL %s C[%0d][%0d] got=%0d exp=%0d", tag, i, j, acc[i][j], ref_c);
        end
      end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_hold obs=%h exp=%h", obs, {VW{1'b0}});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== exp_vec(0)) begin
      errors++;
      $display("FAIL reset_release obs=%h exp=%h", obs, exp_vec(0));
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = (i == j) ? 1 : 0;
        B[i][j] = (i == j) ? 1 : 0;
      end
    run_mult("identity");
  endtask

  task automatic test_skew();
    int rs [N];
    rs = '{10, 26, 42, 58};
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = i * 4 + k + 1;
        B[i][k] = 1;
      end
    run_mult("skew");
    for (int i = 0; i < N; i++) begin
      checks++;
      if (acc[i][0] !== rs[i]) begin
        errors++;
        $display("FAIL skew_rowsum row=%0d got=%0d exp=%0d", i, acc[i][0], rs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      load_random();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_mult("random");
    end
  endtask

  task automatic test_start_held();
    int dones;
    load_random();
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 3 * N + 1; c++) begin
      @(negedge clk);
      if (done) dones++;
      checks++;
      if (obs !== exp_vec(c)) begin
        errors++;
        $display("FAIL held cycle=%0d obs=%h exp=%h", c, obs, exp_vec(c));
      end
    end
    @(negedge clk);
    checks++;
    if (obs !== exp_vec(0)) begin
      errors++;
      $display("FAIL held idle_gap obs=%h exp=%h", obs, exp_vec(0));
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL held done_count got=%0d exp=1", dones);
    end
    load_random();
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (obs !== exp_vec(1)) begin
      errors++;
      $display("FAIL held restart_clear obs=%h exp=%h", obs, exp_vec(1));
    end
    for (int c = 2; c <= 3 * N + 1; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(c)) begin
        errors++;
        $display("FAIL held2 cycle=%0d obs=%h exp=%h", c, obs, exp_vec(c));
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int ref_c;
        ref_c = 0;
        for (int k = 0; k < N; k++) ref_c += A[i][k] * B[k][j];
        checks++;
        if (acc[i][j] !== ref_c) begin
          errors++;
          $display("FAIL held2 C[%0d][%0d] got=%0d exp=%0d", i, j, acc[i][j], ref_c);
        end
      end
  endtask

  task automatic test_abort(input int ca);
    load_random();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ca; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      checks++;
      if (obs !== exp_vec(c)) begin
        errors++;
        $display("FAIL abort_pre cycle=%0d obs=%h exp=%h", c, obs, exp_vec(c));
      end
    end
    abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (obs !== exp_vec(0)) begin
        errors++;
        $display("FAIL abort_at=%0d after=%0d obs=%h exp=%h", ca, c, obs, exp_vec(0));
      end
    end
    load_random();
    run_mult("after_abort");
  endtask

  task automatic test_async_rst();
    load_random();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      checks++;
      if (obs !== exp_vec(c)) begin
        errors++;
        $display("FAIL arst_pre cycle=%0d obs=%h exp=%h", c, obs, exp_vec(c));
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL arst_immediate obs=%h exp=%h", obs, {VW{1'b0}});
    end
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL arst_hold obs=%h exp=%h", obs, {VW{1'b0}});
    end
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== exp_vec(0)) begin
      errors++;
      $display("FAIL arst_release obs=%h exp=%h", obs, exp_vec(0));
    end
    load_random();
    run_mult("after_arst");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_skew();
    test_back_to_back();
    test_start_held();
    test_abort(5);
    for (int r = 0; r < 3; r++) test_abort($urandom_range(1, 3 * N));
    test_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
